seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Inverse of the display path: snoops a multiplexed 7-segment bus (active-low segments plus
//  active-low one-hot digit enables) and reconstructs each digit's value into registers.
//  Used by the dispensing-machine lab to read back what the panel shows (self-check, logging).
//  Filters scan glitches with a stability counter; flags blank and illegal patterns.
// PARAMETERS
//  NDIG    4  number of multiplexed digits (>=2)
//  IDXW    2  width of upd_idx; 2**IDXW >= NDIG
//  STABLE  3  consecutive identical samples required before commit (1..15)
// PORTS
//  clk      in   1       system clock, rising edge
//  rst      in   1       asynchronous, active-high reset
//  seg      in   7       segments, active-low, seg[6]=a .. seg[0]=g
//  an       in   NDIG    digit enables, active-low, legal only with exactly one bit 0
//  digits   out  4*NDIG  digit i value in digits[4i+3:4i]; 4'hF when blank/illegal
//  valid    out  NDIG    valid[i]=1: digits[i] holds a decoded value
//  err      out  NDIG    err[i]=1: last committed pattern on digit i was illegal
//  upd      out  1       one-cycle pulse at each commit
//  upd_idx  out  IDXW    digit index of the commit flagged by upd
// BEHAVIOUR
//  - Reset (async): digits=all 4'hF, valid=0, err=0, upd=0, upd_idx=0, run=0, prev sample=all 1s.
//  - Sample = {an,seg} at every rising edge. Legal when an has exactly one 0 bit.
//  - run counter (4b, saturates at STABLE): illegal sample -> run=0; legal and equal to
//    previous sample with run!=0 -> run=min(run+1,STABLE); otherwise run=1.
//  - Commit at the edge where run becomes STABLE (exactly once per stable run; holding the
//    pattern longer never recommits). Latency: outputs update on the STABLE-th edge of the run.
//  - Commit to digit i (index of the 0 bit in an): decode seg:
//      0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//      5=0100100 6=0100000 7=0001111 8=0000000 9=0001100
//    legal code -> digits[i]=code, valid[i]=1, err[i]=0
//    blank 1111111 -> digits[i]=F, valid[i]=0, err[i]=0
//    anything else -> digits[i]=F, valid[i]=0, err[i]=1
//  - upd=1 for exactly the commit cycle, upd_idx=i; otherwise upd=0, upd_idx holds.
//  - Other digits' registers untouched by a commit.
//  - Anode change, segment change, or illegal an restarts the run (no partial commit).
//  - Reset mid-run: all state cleared immediately; run restarts from 0 after release.
// CONFIGURATION
//  HEX_DECODE_EN defined: also decodes A=0001000 b=1100000 C=0110001 d=1000010
//    E=0110000 F=0111000 to 4'hA..4'hF with valid=1, err=0.
//  HEX_DECODE_EN undefined: those six patterns are illegal (err=1, valid=0, digits=F).
// TESTING
//  1 rst=1 any inputs -> digits=16'hFFFF, valid=0, err=0, upd=0 at once (before any clk edge).
//  2 an=1110, seg=0010010 held 3 edges -> 3rd edge: digits[3:0]=2, valid[0]=1, upd=1,
//    upd_idx=0; held 10 more edges -> upd stays 0.
//  3 an=1101 seg=0100000 for 2 edges then seg=0001100 for 3 -> single commit digits[7:4]=9;
//    value 6 never appears, upd pulses once.
//  4 an=1100 or 1111 for 20 edges with seg=0000000 -> no upd, outputs unchanged.
//  5 an=1011 seg=1111110 x3 -> err[2]=1, valid[2]=0, digits[11:8]=F; then seg=0001000 x3 ->
//    HEX_DECODE_EN: digits[11:8]=A, err[2]=0, valid[2]=1; without: err[2]=1.
//  6 after digit 0 committed, rst pulse mid-run of digit 3 -> all cleared; post-release
//    digit 3 needs full STABLE edges to commit.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Snoops a multiplexed, active-low 7-segment bus and rebuilds the value shown on
//   each digit. A sample {an, seg} must hold steady for STABLE consecutive clock
//   edges before it is committed, which filters out scan glitches. A committed
//   pattern is decoded to a digit value, a blank, or an illegal code.
//   Optional feature: define HEX_DECODE_EN to also decode the hex letters A..F.
//   Without it, those six patterns count as illegal.
module seg_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int IDXW   = 2,
  parameter int STABLE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     an,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     valid,
  output logic [NDIG-1:0]     err,
  output logic                upd,
  output logic [IDXW-1:0]     upd_idx
);

  localparam int         SW       = NDIG + 7;
  localparam logic [3:0] STABLE_C = 4'(STABLE);

  typedef enum logic [1:0] {
    PAT_DIGIT,
    PAT_BLANK,
    PAT_ILLEGAL
  } pat_kind_e;

  typedef struct packed {
    pat_kind_e  kind;
    logic [3:0] value;
  } pat_t;

  // Map an active-low segment pattern (a..g from MSB to LSB) to a digit value.
  function automatic pat_t decode_seg(input logic [6:0] s);
    pat_t p;
    p.kind  = PAT_DIGIT;
    p.value = 4'hF;
    case (s)
      7'b0000001: p.value = 4'h0;
      7'b1001111: p.value = 4'h1;
      7'b0010010: p.value = 4'h2;
      7'b0000110: p.value = 4'h3;
      7'b1001100: p.value = 4'h4;
      7'b0100100: p.value = 4'h5;
      7'b0100000: p.value = 4'h6;
      7'b0001111: p.value = 4'h7;
      7'b0000000: p.value = 4'h8;
      7'b0001100: p.value = 4'h9;
`ifdef HEX_DECODE_EN
      7'b0001000: p.value = 4'hA;
      7'b1100000: p.value = 4'hB;
      7'b0110001: p.value = 4'hC;
      7'b1000010: p.value = 4'hD;
      7'b0110000: p.value = 4'hE;
      7'b0111000: p.value = 4'hF;
`endif
      7'b1111111: p.kind  = PAT_BLANK;
      default:    p.kind  = PAT_ILLEGAL;
    endcase
    return p;
  endfunction

  logic [SW-1:0]       prev_q;
  logic [3:0]          run_q, run_d;
  logic [4*NDIG-1:0]   digits_q;
  logic [NDIG-1:0]     valid_q, err_q;
  logic                upd_q;
  logic [IDXW-1:0]     upd_idx_q, idx_d;

  logic [SW-1:0]       sample;
  logic                legal, same, commit;
  pat_t                pat;

  assign sample = {an, seg};
  assign legal  = $onehot(~an);
  assign same   = (sample == prev_q);
  assign pat    = decode_seg(seg);

  // Stability counter: advance on a repeated legal sample, restart on any change,
  // and commit only on the edge where the run first reaches STABLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    run_d  = 4'd0;
    commit = 1'b0;
    if (legal) begin
      if (same && run_q != 4'd0)
        run_d = (run_q >= STABLE_C) ? STABLE_C : run_q + 4'd1;
      else
        run_d = 4'd1;
      commit = (run_d == STABLE_C) && !(same && run_q == STABLE_C);
    end
  end

  // Index of the single active (low) anode bit.
  always_comb begin
    idx_d = '0;
    for (int i = 0; i < NDIG; i++)
      if (!an[i]) idx_d = IDXW'(i);
  end

  // Sample history, run counter and per-digit result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '1;
      run_q     <= 4'd0;
      digits_q  <= '1;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      prev_q <= sample;
      run_q  <= run_d;
      upd_q  <= commit;
      if (commit) upd_idx_q <= idx_d;
      for (int i = 0; i < NDIG; i++) begin
        if (commit && !an[i]) begin
          digits_q[4*i +: 4] <= (pat.kind == PAT_DIGIT) ? pat.value : 4'hF;
          valid_q[i]         <= (pat.kind == PAT_DIGIT);
          err_q[i]           <= (pat.kind == PAT_ILLEGAL);
        end
      end
    end
  end

  assign digits  = digits_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed, table-driven bench for seg_scan_decoder with default parameters.
// It follows HEX_DECODE_EN for the expected value of the hex-letter commit.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  valid, err;
  logic        upd;
  logic [1:0]  upd_idx;

  int total = 0;
  int bad   = 0;

`ifdef HEX_DECODE_EN
  localparam logic [3:0] HEX_A = 4'hA;
  localparam logic       HEX_V = 1'b1;
`else
  localparam logic [3:0] HEX_A = 4'hF;
  localparam logic       HEX_V = 1'b0;
`endif

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        upd;
    logic [1:0]  idx;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  seg_scan_decoder #(.NDIG(4), .IDXW(2), .STABLE(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg     (seg),
    .an      (an),
    .digits  (digits),
    .valid   (valid),
    .err     (err),
    .upd     (upd),
    .upd_idx (upd_idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic u, input logic [1:0] ix,
                           input logic [15:0] d, input logic [3:0] v, input logic [3:0] e);
    check({tag, " upd"},     32'(upd),     32'(u));
    check({tag, " upd_idx"}, 32'(upd_idx), 32'(ix));
    check({tag, " digits"},  32'(digits),  32'(d));
    check({tag, " valid"},   32'(valid),   32'(v));
    check({tag, " err"},     32'(err),     32'(e));
  endtask

  // Drive inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic [3:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] a, input logic [6:0] s, input logic u,
                              input logic [1:0] ix, input logic [15:0] d,
                              input logic [3:0] v, input logic [3:0] e);
    vec_t r;
    r.an = a; r.seg = s; r.upd = u; r.idx = ix; r.digits = d; r.valid = v; r.err = e;
    return r;
  endfunction

  initial begin
    // Reset is asynchronous: outputs clear before any clock edge.
    rst = 1'b1;
    an  = 4'($urandom);
    seg = 7'($urandom);
    #1;
    check_all("reset0", 1'b0, 2'd0, 16'hFFFF, 4'h0, 4'h0);
    an  = 4'b1111;
    seg = 7'h7F;
    #3;
    rst = 1'b0;

    // Digit 0 shows 2: commit on the 3rd edge, then 10 more edges with no recommit.
    vecs.push_back(mk(4'b1110, 7'b0010010, 0, 0, 16'hFFFF, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1110, 7'b0010010, 0, 0, 16'hFFFF, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1110, 7'b0010010, 1, 0, 16'hFFF2, 4'b0001, 4'b0000));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(4'b1110, 7'b0010010, 0, 0, 16'hFFF2, 4'b0001, 4'b0000));
    // Digit 1: 6 for two edges (too short), then 9 for three -> only 9 commits.
    vecs.push_back(mk(4'b1101, 7'b0100000, 0, 0, 16'hFFF2, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b1101, 7'b0100000, 0, 0, 16'hFFF2, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b1101, 7'b0001100, 0, 0, 16'hFFF2, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b1101, 7'b0001100, 0, 0, 16'hFFF2, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b1101, 7'b0001100, 1, 1, 16'hFF92, 4'b0011, 4'b0000));
    // Illegal anodes for 20 edges: nothing commits.
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk((i < 10) ? 4'b1100 : 4'b1111, 7'b0000000, 0, 1, 16'hFF92, 4'b0011, 4'b0000));
    // Digit 2: illegal segment code, then the hex letter A.
    vecs.push_back(mk(4'b1011, 7'b1111110, 0, 1, 16'hFF92, 4'b0011, 4'b0000));
    vecs.push_back(mk(4'b1011, 7'b1111110, 0, 1, 16'hFF92, 4'b0011, 4'b0000));
    vecs.push_back(mk(4'b1011, 7'b1111110, 1, 2, 16'hFF92, 4'b0011, 4'b0100));
    vecs.push_back(mk(4'b1011, 7'b0001000, 0, 2, 16'hFF92, 4'b0011, 4'b0100));
    vecs.push_back(mk(4'b1011, 7'b0001000, 0, 2, 16'hFF92, 4'b0011, 4'b0100));
    vecs.push_back(mk(4'b1011, 7'b0001000, 1, 2, {4'hF, HEX_A, 8'h92},
                      {1'b0, HEX_V, 2'b11}, {1'b0, ~HEX_V, 2'b00}));
    // Digit 0 goes blank: value F, valid and err both clear.
    vecs.push_back(mk(4'b1110, 7'b1111111, 0, 2, {4'hF, HEX_A, 8'h92}, {1'b0, HEX_V, 2'b11}, {1'b0, ~HEX_V, 2'b00}));
    vecs.push_back(mk(4'b1110, 7'b1111111, 0, 2, {4'hF, HEX_A, 8'h92}, {1'b0, HEX_V, 2'b11}, {1'b0, ~HEX_V, 2'b00}));
    vecs.push_back(mk(4'b1110, 7'b1111111, 1, 0, {4'hF, HEX_A, 8'h9F}, {1'b0, HEX_V, 2'b10}, {1'b0, ~HEX_V, 2'b00}));
    // Digit 3 shows 3, interrupted by one illegal anode sample: run restarts.
    vecs.push_back(mk(4'b0111, 7'b0000110, 0, 0, {4'hF, HEX_A, 8'h9F}, {1'b0, HEX_V, 2'b10}, {1'b0, ~HEX_V, 2'b00}));
    vecs.push_back(mk(4'b0111, 7'b0000110, 0, 0, {4'hF, HEX_A, 8'h9F}, {1'b0, HEX_V, 2'b10}, {1'b0, ~HEX_V, 2'b00}));
    vecs.push_back(mk(4'b0011, 7'b0000110, 0, 0, {4'hF, HEX_A, 8'h9F}, {1'b0, HEX_V, 2'b10}, {1'b0, ~HEX_V, 2'b00}));
    vecs.push_back(mk(4'b0111, 7'b0000110, 0, 0, {4'hF, HEX_A, 8'h9F}, {1'b0, HEX_V, 2'b10}, {1'b0, ~HEX_V, 2'b00}));
    vecs.push_back(mk(4'b0111, 7'b0000110, 0, 0, {4'hF, HEX_A, 8'h9F}, {1'b0, HEX_V, 2'b10}, {1'b0, ~HEX_V, 2'b00}));
    vecs.push_back(mk(4'b0111, 7'b0000110, 1, 3, {4'h3, HEX_A, 8'h9F}, {1'b1, HEX_V, 2'b10}, {1'b0, ~HEX_V, 2'b00}));
    // Digit 0 shows 8 before the reset sequence.
    vecs.push_back(mk(4'b1110, 7'b0000000, 0, 3, {4'h3, HEX_A, 8'h9F}, {1'b1, HEX_V, 2'b10}, {1'b0, ~HEX_V, 2'b00}));
    vecs.push_back(mk(4'b1110, 7'b0000000, 0, 3, {4'h3, HEX_A, 8'h9F}, {1'b1, HEX_V, 2'b10}, {1'b0, ~HEX_V, 2'b00}));
    vecs.push_back(mk(4'b1110, 7'b0000000, 1, 0, {4'h3, HEX_A, 8'h98}, {1'b1, HEX_V, 2'b11}, {1'b0, ~HEX_V, 2'b00}));

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].an, vecs[k].seg);
      check_all($sformatf("vec%0d", k), vecs[k].upd, vecs[k].idx, vecs[k].digits,
                vecs[k].valid, vecs[k].err);
    end

    // Reset in the middle of a digit-3 run of 5, then a full run after release.
    step(4'b0111, 7'b0100100);
    step(4'b0111, 7'b0100100);
    check("pre-reset upd", 32'(upd), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_all("midreset", 1'b0, 2'd0, 16'hFFFF, 4'h0, 4'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(4'b0111, 7'b0100100);
    check_all("post1", 1'b0, 2'd0, 16'hFFFF, 4'h0, 4'h0);
    step(4'b0111, 7'b0100100);
    check_all("post2", 1'b0, 2'd0, 16'hFFFF, 4'h0, 4'h0);
    step(4'b0111, 7'b0100100);
    check_all("post3", 1'b1, 2'd3, 16'h5FFF, 4'b1000, 4'h0);
    step(4'b0111, 7'b0100100);
    check_all("post4", 1'b0, 2'd3, 16'h5FFF, 4'b1000, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
